stream_mux_arb: RTL and testbench
=================================

# stream_mux_arb

Parametrised N-input, WIDTH-bit registered multiplexer with a valid/ready handshake on every port and a built-in arbiter. It supersedes the plain 2:1 select mux wherever several producers share one consumer, e.g. instruction-fetch vs. load/store requests onto the single memory port, or multiple write-back sources onto the register-file write port. Selection is made by the block itself, using fixed-priority or round-robin arbitration. The chosen word is registered, so the consumer sees a stable, glitch-free output.

## Interface
- WIDTH, 32, data width in bits of each input and of the output (≥1)
- N, 2, number of input channels (≥2)
- RR, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round robin
- SELW (localparam), max(1, $clog2(N)), width of the channel index

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  N  bit i: channel i presents a word
- in_ready  out  N  bit i: channel i's word is accepted this cycle
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  WIDTH  registered selected word
- out_sel  out  SELW  index of the channel that produced out_data

## Operation
- Output stage is a single-entry register with state EMPTY (out_valid=0) or FULL (out_valid=1).
- can_load = !out_valid | out_ready.
- Grant is combinational from in_valid and the priority pointer ptr:
  - RR=0: grant = lowest i with in_valid[i]; ptr is unused and stays 0.
  - RR=1: grant = first i with in_valid[i], searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
- in_ready[i] = can_load & any(in_valid) & (grant == i) & !rst. At most one bit is high. in_ready never depends on in_ready.
- Transfer on channel i: in_valid[i] & in_ready[i]. On the next edge:
  - out_data ← in_data[i]
  - out_sel ← i
  - out_valid ← 1
  - if RR=1: ptr ← (i == N-1) ? 0 : i+1
- Output pop: out_valid & out_ready with no transfer in the same cycle. Next edge: out_valid ← 0; out_data and out_sel keep their last values.
- Simultaneous pop and transfer: the register is overwritten with the new word and out_valid stays 1. This gives full throughput of one word per cycle.
- While FULL and out_ready=0: out_data and out_sel are held constant, and all in_ready bits are 0.
- ptr changes only on a transfer. Idle cycles and out_ready stalls leave it unchanged.
- Producers must hold in_valid and in_data until accepted. The block does not check this. A producer dropping in_valid before acceptance simply loses arbitration, with no side effect.
- N not a power of two: ptr wraps explicitly at N-1. Index values ≥ N never appear on out_sel.

## Timing
- Reset (async assert, any cycle, including while FULL or mid-transfer):
  - immediately: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0
  - any pending output word is discarded
- Release is synchronous to clk. The first transfer can occur in the first cycle after rst deasserts.
- Latency: input accepted at edge k → out_valid=1 with that data after edge k.
- Throughput: 1 word/cycle with out_ready held high. It is 0 while the consumer stalls.
- Fairness, RR=1: with all N channels continuously valid and out_ready=1, each channel is granted exactly once in every N consecutive transfers.

## Test plan
- **Reset:** assert rst mid-stream while out_valid=1 and out_data=0xDEADBEEF → out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately, before any clk edge. After release, the first grant in RR=1 goes to channel 0.
- **Fixed priority** (N=4, RR=0): in_valid=4'b1010, data ch1=0x11, ch3=0x33, out_ready=1 → out_data=0x11/out_sel=1 for every cycle ch1 stays valid. ch3 is granted (0x33, sel 3) only in the cycle after ch1 drops.
- **Round robin** (N=3, RR=1): all valid, data = 0xA0+i, out_ready=1 for 6 cycles → out_sel sequence 0,1,2,0,1,2, with out_data matching. Repeat with N=3 and only ch0, ch2 valid → sequence 0,2,0,2 (wrap past index 2).
- **Back-pressure:** out_valid=1 with 0x55, out_ready=0 for 5 cycles, all inputs valid → out_data=0x55 and out_sel stable, in_ready=0 throughout, ptr unchanged. When out_ready rises, the next word loads in the same cycle as the pop, and out_valid never drops.
- **Drain:** single transfer, then in_valid=0 and out_ready=1 → out_valid falls after one edge, out_data retains its last value.
- **Random soak:** random valid/ready for N∈{2,3,5}, WIDTH∈{1,32}, both modes → a scoreboard checks that each word is delivered exactly once and in per-channel order, at most one in_ready bit is high, and the RR fairness bound holds.

Source files
------------

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-input valid/ready stream mux with built-in arbiter
// (fixed priority or round robin) feeding a single registered output.
//
// Ports:
//   clk, rst   - rising-edge clock, async active-high reset
//   in_valid   - [N] per-channel word present
//   in_ready   - [N] per-channel word accepted this cycle (one-hot or 0)
//   in_data    - [N*WIDTH] channel i at [i*WIDTH +: WIDTH]
//   out_valid  - output register holds a word
//   out_ready  - consumer takes out_data this cycle
//   out_data   - [WIDTH] registered selected word
//   out_sel    - [SELW] index of the channel that produced out_data
module stream_mux_arb #(
    parameter int WIDTH = 32,
    parameter int N     = 2,
    parameter int RR    = 0,
    localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  start;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] sel_data;
    logic             any_valid;
    logic             can_load;
    logic             xfer;

    // In fixed-priority mode the search always starts at channel 0.
    assign start = (RR != 0) ? ptr : '0;

    // Each channel's distance from the pointer (mod N); the nearest
    // valid channel wins. Strict '<' keeps the first one found.
    always_comb begin
        int best;
        int pos;
        best  = N;
        pos   = 0;
        grant = '0;
        for (int i = 0; i < N; i++) begin
            pos = i - int'(start);
            if (pos < 0) pos = pos + N;
            if (in_valid[i] && pos < best) begin
                best  = pos;
                grant = SELW'(i);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign any_valid = |in_valid;
    assign can_load  = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        if (can_load && any_valid && !rst) begin
            in_ready = {{(N-1){1'b0}}, 1'b1} << grant;
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_sel   <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Explicit wrap so non-power-of-two N never indexes past N-1.
            if (xfer && RR != 0) begin
                ptr <= (int'(grant) == N - 1) ? '0 : grant + SELW'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed and soak checks of stream_mux_arb
// in fixed-priority (N=4) and round-robin (N=3, N=5) configurations.
module tb_stream_mux_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0]   fp_iv, fp_ir;
    logic [127:0] fp_id;
    logic         fp_ov, fp_or;
    logic [31:0]  fp_od;
    logic [1:0]   fp_os;

    logic [2:0]   rr_iv, rr_ir;
    logic [95:0]  rr_id;
    logic         rr_ov, rr_or;
    logic [31:0]  rr_od;
    logic [1:0]   rr_os;

    logic [4:0]   sk_iv, sk_ir;
    logic [159:0] sk_id;
    logic         sk_ov, sk_or;
    logic [31:0]  sk_od;
    logic [2:0]   sk_os;

    stream_mux_arb #(.WIDTH(32), .N(4), .RR(0)) u_fp (
        .clk(clk), .rst(rst),
        .in_valid(fp_iv), .in_ready(fp_ir), .in_data(fp_id),
        .out_valid(fp_ov), .out_ready(fp_or),
        .out_data(fp_od), .out_sel(fp_os)
    );

    stream_mux_arb #(.WIDTH(32), .N(3), .RR(1)) u_rr (
        .clk(clk), .rst(rst),
        .in_valid(rr_iv), .in_ready(rr_ir), .in_data(rr_id),
        .out_valid(rr_ov), .out_ready(rr_or),
        .out_data(rr_od), .out_sel(rr_os)
    );

    stream_mux_arb #(.WIDTH(32), .N(5), .RR(1)) u_sk (
        .clk(clk), .rst(rst),
        .in_valid(sk_iv), .in_ready(sk_ir), .in_data(sk_id),
        .out_valid(sk_ov), .out_ready(sk_or),
        .out_data(sk_od), .out_sel(sk_os)
    );

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        fp_iv = 4'hF; fp_id = '0; fp_or = 1'b0;
        rr_iv = '0;   rr_id = '0; rr_or = 1'b0;
        sk_iv = '0;   sk_id = '0; sk_or = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (fp_ov !== 1'b0 || fp_od !== 32'h0 || fp_os !== 2'd0) begin
            errors++;
            $display("FAIL reset_init ov=%b od=%h os=%0d exp 0/0/0", fp_ov, fp_od, fp_os);
        end
        checks++;
        if (fp_ir !== 4'b0000) begin
            errors++;
            $display("FAIL reset_init_ready got=%b exp=0000", fp_ir);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        fp_iv = 4'b0001; fp_id = {96'h0, 32'hDEADBEEF};
        rr_iv = 3'b010;  rr_or = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (fp_ov !== 1'b1 || fp_od !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_preload ov=%b od=%h exp 1/deadbeef", fp_ov, fp_od);
        end
        checks++;
        if (rr_os !== 2'd1) begin
            errors++;
            $display("FAIL reset_rr_preload got=%0d exp=1", rr_os);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (fp_ov !== 1'b0 || fp_od !== 32'h0 || fp_os !== 2'd0) begin
            errors++;
            $display("FAIL reset_async ov=%b od=%h os=%0d exp 0/0/0", fp_ov, fp_od, fp_os);
        end
        checks++;
        if (fp_ir !== 4'b0000 || rr_ir !== 3'b000) begin
            errors++;
            $display("FAIL reset_async_ready fp=%b rr=%b exp 0/0", fp_ir, rr_ir);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rr_iv = 3'b111;
        #1;
        checks++;
        if (rr_ir !== 3'b001) begin
            errors++;
            $display("FAIL reset_rr_first got=%b exp=001", rr_ir);
        end
        fp_iv = '0;
        rr_iv = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fixed_priority;
        do_reset();
        fp_id = {32'h33, 32'h0, 32'h11, 32'h0};
        fp_iv = 4'b1010;
        fp_or = 1'b1;
        #1;
        checks++;
        if (fp_ir !== 4'b0010) begin
            errors++;
            $display("FAIL fp_ready got=%b exp=0010", fp_ir);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (fp_ov !== 1'b1 || fp_od !== 32'h11 || fp_os !== 2'd1) begin
                errors++;
                $display("FAIL fp_ch1 cyc=%0d ov=%b od=%h os=%0d exp 1/11/1", i, fp_ov, fp_od, fp_os);
            end
        end
        fp_iv = 4'b1000;
        #1;
        checks++;
        if (fp_ir !== 4'b1000) begin
            errors++;
            $display("FAIL fp_ready_ch3 got=%b exp=1000", fp_ir);
        end
        @(posedge clk);
        #1;
        checks++;
        if (fp_ov !== 1'b1 || fp_od !== 32'h33 || fp_os !== 2'd3) begin
            errors++;
            $display("FAIL fp_ch3 ov=%b od=%h os=%0d exp 1/33/3", fp_ov, fp_od, fp_os);
        end
        fp_iv = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        do_reset();
        rr_id = {32'hA2, 32'hA1, 32'hA0};
        rr_iv = 3'b111;
        rr_or = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp = 2'(i % 3);
            @(posedge clk);
            #1;
            checks++;
            if (rr_ov !== 1'b1 || rr_os !== exp || rr_od !== 32'hA0 + 32'(exp)) begin
                errors++;
                $display("FAIL rr_all cyc=%0d os=%0d od=%h exp %0d/%h", i, rr_os, rr_od, exp, 32'hA0 + 32'(exp));
            end
        end
        rr_iv = '0;
        do_reset();
        rr_iv = 3'b101;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 1) ? 2'd2 : 2'd0;
            @(posedge clk);
            #1;
            checks++;
            if (rr_os !== exp || rr_od !== 32'hA0 + 32'(exp)) begin
                errors++;
                $display("FAIL rr_wrap cyc=%0d os=%0d od=%h exp %0d/%h", i, rr_os, rr_od, exp, 32'hA0 + 32'(exp));
            end
        end
        rr_iv = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_pressure;
        do_reset();
        rr_id = {32'h0, 32'h55, 32'h0};
        rr_iv = 3'b010;
        rr_or = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rr_ov !== 1'b1 || rr_od !== 32'h55 || rr_os !== 2'd1) begin
            errors++;
            $display("FAIL bp_load ov=%b od=%h os=%0d exp 1/55/1", rr_ov, rr_od, rr_os);
        end
        rr_id = {32'h62, 32'h61, 32'h60};
        rr_iv = 3'b111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rr_ir !== 3'b000) begin
                errors++;
                $display("FAIL bp_ready cyc=%0d got=%b exp=000", i, rr_ir);
            end
            @(posedge clk);
            #1;
            checks++;
            if (rr_ov !== 1'b1 || rr_od !== 32'h55 || rr_os !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d ov=%b od=%h os=%0d exp 1/55/1", i, rr_ov, rr_od, rr_os);
            end
        end
        rr_or = 1'b1;
        #1;
        checks++;
        if (rr_ir !== 3'b100) begin
            errors++;
            $display("FAIL bp_ptr got=%b exp=100", rr_ir);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rr_ov !== 1'b1 || rr_od !== 32'h62 || rr_os !== 2'd2) begin
            errors++;
            $display("FAIL bp_release ov=%b od=%h os=%0d exp 1/62/2", rr_ov, rr_od, rr_os);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rr_ov !== 1'b1 || rr_od !== 32'h60 || rr_os !== 2'd0) begin
            errors++;
            $display("FAIL bp_next ov=%b od=%h os=%0d exp 1/60/0", rr_ov, rr_od, rr_os);
        end
        rr_iv = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_drain;
        do_reset();
        fp_id = {32'h0, 32'h77, 32'h0, 32'h0};
        fp_iv = 4'b0100;
        fp_or = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (fp_ov !== 1'b1 || fp_od !== 32'h77 || fp_os !== 2'd2) begin
            errors++;
            $display("FAIL drain_load ov=%b od=%h os=%0d exp 1/77/2", fp_ov, fp_od, fp_os);
        end
        fp_iv = '0;
        @(posedge clk);
        #1;
        checks++;
        if (fp_ov !== 1'b0 || fp_od !== 32'h77 || fp_os !== 2'd2) begin
            errors++;
            $display("FAIL drain_empty ov=%b od=%h os=%0d exp 0/77/2", fp_ov, fp_od, fp_os);
        end
    endtask

    task automatic test_soak;
        int sent[5];
        int rcvd[5];
        int waitc[5];
        logic [4:0] acc;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            sent[c] = 0; rcvd[c] = 0; waitc[c] = 0;
        end
        sk_iv = '0;
        for (int cyc = 0; cyc < 800 + 3; cyc++) begin
            if (cyc < 800) begin
                for (int c = 0; c < 5; c++) begin
                    if (!sk_iv[c] && $urandom_range(0, 2) != 0) begin
                        sk_iv[c] = 1'b1;
                        sk_id[c*32 +: 32] = {8'(c), 24'(sent[c])};
                    end
                end
                sk_or = ($urandom_range(0, 3) != 0);
            end else begin
                sk_iv = '0;
                sk_or = 1'b1;
            end
            #1;
            checks++;
            if (!$onehot0(sk_ir)) begin
                errors++;
                $display("FAIL soak_onehot cyc=%0d got=%b exp at most one bit", cyc, sk_ir);
            end
            if (sk_ov && sk_or) begin
                checks++;
                if (sk_os > 3'd4) begin
                    errors++;
                    $display("FAIL soak_sel cyc=%0d got=%0d exp <5", cyc, sk_os);
                end else if (sk_od[31:24] !== 8'(sk_os) || sk_od[23:0] !== 24'(rcvd[sk_os])) begin
                    errors++;
                    $display("FAIL soak_order cyc=%0d got=%h exp=%h", cyc, sk_od, {8'(sk_os), 24'(rcvd[sk_os])});
                    rcvd[sk_os]++;
                end else begin
                    rcvd[sk_os]++;
                end
            end
            acc = sk_iv & sk_ir;
            if (acc != '0) begin
                for (int c = 0; c < 5; c++) begin
                    if (acc[c]) begin
                        sent[c]++;
                        waitc[c] = 0;
                    end else if (sk_iv[c]) begin
                        waitc[c]++;
                        checks++;
                        if (waitc[c] > 4) begin
                            errors++;
                            $display("FAIL soak_fair cyc=%0d ch=%0d waited=%0d exp <=4", cyc, c, waitc[c]);
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            sk_iv = sk_iv & ~acc;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rcvd[c] !== sent[c] || sent[c] == 0) begin
                errors++;
                $display("FAIL soak_count ch=%0d got=%0d exp=%0d (nonzero)", c, rcvd[c], sent[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_back_pressure();
        test_drain();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
